memcpy_burst_sequencer: RTL

- Sequences the pattern memcpy datapath. It takes the source address, target address, byte count and enable from the action register block, and splits the copy into AXI-legal bursts.
- Each burst goes out as a paired read command and write command to the host AXI master engines.
- It limits the number of bursts in flight and reports completion as `pattern_memcpy_done`. The register block consumes this signal, together with its FIFO-empty status, to form the delayed done.

---
 rtl/memcpy_burst_sequencer_if.sv | 27 ++
 rtl/memcpy_burst_sequencer.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/memcpy_burst_sequencer_if.sv
// Command/response bundle between the memcpy burst sequencer and the host
// AXI master engines: paired read/write burst commands plus the write B
// response strobe used for credit return and error reporting.
interface memcpy_burst_sequencer_if;
    logic        rd_cmd_valid;
    logic        rd_cmd_ready;
    logic [63:0] rd_cmd_addr;
    logic [7:0]  rd_cmd_len;
    logic        wr_cmd_valid;
    logic        wr_cmd_ready;
    logic [63:0] wr_cmd_addr;
    logic [7:0]  wr_cmd_len;
    logic        wr_burst_done;
    logic        wr_burst_err;

    modport master (
        output rd_cmd_valid, rd_cmd_addr, rd_cmd_len,
        output wr_cmd_valid, wr_cmd_addr, wr_cmd_len,
        input  rd_cmd_ready, wr_cmd_ready, wr_burst_done, wr_burst_err
    );

    modport slave (
        input  rd_cmd_valid, rd_cmd_addr, rd_cmd_len,
        input  wr_cmd_valid, wr_cmd_addr, wr_cmd_len,
        output rd_cmd_ready, wr_cmd_ready, wr_burst_done, wr_burst_err
    );
endinterface

// File: rtl/memcpy_burst_sequencer.sv
// Memcpy burst sequencer: splits a copy into AXI-legal bursts (max length,
// no 4 KB crossing on either address), issues each as a paired read/write
// command, limits bursts in flight and reports completion and errors.
module memcpy_burst_sequencer #(
    parameter int unsigned DATA_BYTES      = 64,
    parameter int unsigned MAX_BURST_BEATS = 64,
    parameter int unsigned MAX_OUTSTANDING = 8,
    parameter int unsigned CNT_WIDTH       = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     pattern_memcpy_enable,
    input  logic [63:0]              pattern_source_address,
    input  logic [63:0]              pattern_target_address,
    input  logic [63:0]              pattern_total_number,
    memcpy_burst_sequencer_if.master bus,
    output logic                     pattern_memcpy_done,
    output logic                     memcpy_error,
    output logic [CNT_WIDTH-1:0]     burst_count,
    output logic                     busy
);

    localparam int unsigned OFS = $clog2(DATA_BYTES);
    localparam int unsigned OW  = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [63:0] MAX_BYTES = 64'(MAX_BURST_BEATS * DATA_BYTES);
    localparam logic [63:0] BYTE_MASK = 64'(DATA_BYTES - 1);
    localparam logic [OW-1:0] OUT_MAX = OW'(MAX_OUTSTANDING);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CALC,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic            en_q;
    logic [63:0]     src_q, tgt_q, rem_q, chunk_q;
    logic [7:0]      len_q;
    logic            rd_pend_q, wr_pend_q;
    logic [OW-1:0]   outst_q;
    logic            done_q, err_q;
    logic [CNT_WIDTH-1:0] cnt_q;

    logic            start;
    logic            rd_valid, wr_valid, rd_fire, wr_fire, issue;
    logic            stall, abort;
    logic [63:0]     src_room, tgt_room, chunk_d;
    logic [7:0]      len_d;

    assign start    = pattern_memcpy_enable && !en_q && (state_q == S_IDLE);
    assign stall    = (outst_q == OUT_MAX);
    // Abort only while neither half of the burst has been accepted; a
    // half-accepted burst must still complete its other command.
    assign abort    = err_q && rd_pend_q && wr_pend_q;
    assign src_room = 64'd4096 - {52'd0, src_q[11:0]};
    assign tgt_room = 64'd4096 - {52'd0, tgt_q[11:0]};

    // Burst size: smallest of remaining, max burst and both 4 KB page rooms.
    always_comb begin
        chunk_d = rem_q;
        if (chunk_d > MAX_BYTES) chunk_d = MAX_BYTES;
        if (chunk_d > src_room)  chunk_d = src_room;
        if (chunk_d > tgt_room)  chunk_d = tgt_room;
        len_d = 8'((chunk_d >> OFS) - 64'd1);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic and command handshakes.
    always_comb begin
        state_d  = state_q;
        rd_valid = 1'b0;
        wr_valid = 1'b0;
        rd_fire  = 1'b0;
        wr_fire  = 1'b0;
        issue    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_CALC;
            end
            S_CALC: begin
                if (err_q || rem_q == 64'd0) state_d = S_DRAIN;
                else                         state_d = S_ISSUE;
            end
            S_ISSUE: begin
                if (abort) begin
                    state_d = S_DRAIN;
                end else if (!stall) begin
                    rd_valid = rd_pend_q;
                    wr_valid = wr_pend_q;
                    rd_fire  = rd_valid && bus.rd_cmd_ready;
                    wr_fire  = wr_valid && bus.wr_cmd_ready;
                    if ((!rd_pend_q || rd_fire) && (!wr_pend_q || wr_fire)) begin
                        issue   = 1'b1;
                        state_d = S_CALC;
                    end
                end
            end
            S_DRAIN: begin
                if (outst_q == '0) state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Copy datapath: latch on start, size in CALC, advance on issue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q      <= 1'b0;
            src_q     <= '0;
            tgt_q     <= '0;
            rem_q     <= '0;
            chunk_q   <= '0;
            len_q     <= '0;
            rd_pend_q <= 1'b0;
            wr_pend_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            en_q <= pattern_memcpy_enable;
            if (start) begin
                src_q  <= pattern_source_address;
                tgt_q  <= pattern_target_address;
                rem_q  <= pattern_total_number & ~BYTE_MASK;
                done_q <= 1'b0;
                err_q  <= 1'b0;
                cnt_q  <= '0;
            end else if (bus.wr_burst_done && bus.wr_burst_err) begin
                err_q <= 1'b1;
            end
            if (state_q == S_CALC && rem_q != 64'd0) begin
                chunk_q   <= chunk_d;
                len_q     <= len_d;
                rd_pend_q <= 1'b1;
                wr_pend_q <= 1'b1;
            end
            if (rd_fire) rd_pend_q <= 1'b0;
            if (wr_fire) wr_pend_q <= 1'b0;
            if (issue) begin
                src_q <= src_q + chunk_q;
                tgt_q <= tgt_q + chunk_q;
                rem_q <= rem_q - chunk_q;
                if (cnt_q != '1) cnt_q <= cnt_q + CNT_WIDTH'(1);
            end
            if (state_q == S_DONE) done_q <= 1'b1;
        end
    end

    // Bursts in flight: +1 on issue, -1 on B response, never below zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outst_q <= '0;
        end else begin
            case ({issue, bus.wr_burst_done && outst_q != '0})
                2'b10:   outst_q <= outst_q + OW'(1);
                2'b01:   outst_q <= outst_q - OW'(1);
                default: outst_q <= outst_q;
            endcase
        end
    end

    assign bus.rd_cmd_valid    = rd_valid;
    assign bus.rd_cmd_addr     = src_q;
    assign bus.rd_cmd_len      = len_q;
    assign bus.wr_cmd_valid    = wr_valid;
    assign bus.wr_cmd_addr     = tgt_q;
    assign bus.wr_cmd_len      = len_q;
    assign pattern_memcpy_done = done_q;
    assign memcpy_error        = err_q;
    assign burst_count         = cnt_q;
    assign busy                = (state_q != S_IDLE);

endmodule
